// File: rtl/stim_trace_unit.sv
// Stimulus generator and change tracer for a processor-style DUT, with a FWFT trace FIFO.
// Optional build macro TRACE_FILTER_EN adds cfg_mask to restrict which bits count as a change.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// RUN    | driving stimulus, tracing dut_out, counting cycles
// DONE   | run ended by timeout or stop; trace still readable
module stim_trace_unit #(
   parameter int DATA_W  = 32,
   parameter int TS_W    = 32,
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 3000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     stop,
   input  logic [1:0]               cfg_mode,
   input  logic [DATA_W-1:0]        cfg_const,
`ifdef TRACE_FILTER_EN
   input  logic [DATA_W-1:0]        cfg_mask,
`endif
   output logic [DATA_W-1:0]        stim_out,
   input  logic [DATA_W-1:0]        dut_out,
   output logic                     trace_valid,
   output logic [DATA_W-1:0]        trace_data,
   output logic [TS_W-1:0]          trace_ts,
   input  logic                     trace_rd,
   output logic [$clog2(DEPTH):0]   trace_count,
   output logic                     overflow,
   output logic                     running,
   output logic                     done
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = TS_W + DATA_W;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
   localparam bit HAS_TIMEOUT = (TIMEOUT != 0);
   localparam logic [TS_W-1:0] TS_LAST = TS_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   logic [1:0]        state;
   logic [TS_W-1:0]   ts;
   logic [31:0]       lfsr;
   logic              first;
   logic [DATA_W-1:0] prev;
   logic [EW-1:0]     mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;

   logic              run_edge;
   logic              start_edge;
   logic              last;
   logic              step;
   logic              changed;
   logic              push_req;
   logic              push;
   logic              pop;
   logic              full;
   logic [TS_W-1:0]   ts_nxt;
   logic [31:0]       lfsr_nxt;
   logic [DATA_W-1:0] stim_nxt;

   assign run_edge   = (state == S_RUN);
   assign start_edge = start && (state != S_RUN);
   assign last       = run_edge && (stop || (HAS_TIMEOUT && (ts == TS_LAST)));
   assign step       = run_edge && !last;

`ifdef TRACE_FILTER_EN
   assign changed = ((dut_out ^ prev) & cfg_mask) != '0;
`else
   assign changed = (dut_out != prev);
`endif

   assign full     = (count == CW'(DEPTH));
   assign pop      = trace_rd && (count != '0);
   assign push_req = run_edge && (first || changed);
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign push     = push_req && (!full || pop);

   assign ts_nxt   = start_edge ? '0 : ts + TS_W'(1);
   assign lfsr_nxt = start_edge ? 32'h1
                   : ({1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : 32'h0));

   always_comb begin
      stim_nxt = stim_out;
      case (cfg_mode)
         2'd0:    stim_nxt = DATA_W'(ts_nxt);
         2'd1:    stim_nxt = DATA_W'(lfsr_nxt);
         2'd2:    stim_nxt = cfg_const;
         default: stim_nxt = stim_out;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         ts       <= '0;
         lfsr     <= 32'h1;
         stim_out <= '0;
         first    <= 1'b0;
         prev     <= '0;
         running  <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         if (start_edge) begin
            state   <= S_RUN;
            running <= 1'b1;
            done    <= 1'b0;
            first   <= 1'b1;
         end else if (last) begin
            state   <= S_DONE;
            running <= 1'b0;
            done    <= 1'b1;
         end

         if (start_edge || run_edge) ts <= ts_nxt;
         // The exit edge leaves stim_out alone so it holds through DONE.
         if (start_edge || step) begin
            lfsr     <= lfsr_nxt;
            stim_out <= stim_nxt;
         end
         if (run_edge) begin
            first <= 1'b0;
            prev  <= dut_out;
         end

         if (start_edge) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
            if (push_req && full && !pop) overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {ts, dut_out};
   end

   assign trace_valid = (count != '0);
   assign trace_count = count;
   assign trace_data  = trace_valid ? mem[rd_ptr][DATA_W-1:0] : '0;
   assign trace_ts    = trace_valid ? mem[rd_ptr][EW-1:DATA_W] : '0;

endmodule

// File: tb/tb_stim_trace_unit.sv
// Bench for stim_trace_unit: two instances (TIMEOUT=8/DEPTH=16 and TIMEOUT=0/DEPTH=4),
// one active at a time, checked against a queue-based model and a popping scoreboard.
module tb_stim_trace_unit;
   localparam int DW = 32;
   localparam int TW = 32;
   localparam int TO_A = 8;
   localparam int DEPTH_A = 16;
   localparam int TO_B = 0;
   localparam int DEPTH_B = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          trace_rd = 1'b0;
   logic [1:0]    cfg_mode = 2'd0;
   logic [DW-1:0] cfg_const = '0;
   logic [DW-1:0] dut_in = '0;
   int            sel = 0;
   logic          rst_a, rst_b;

   assign rst_a = rst || (sel != 0);
   assign rst_b = rst || (sel != 1);

   logic [DW-1:0] a_stim, a_data, b_stim, b_data;
   logic [TW-1:0] a_ts, b_ts;
   logic          a_valid, a_ovf, a_run, a_done, b_valid, b_ovf, b_run, b_done;
   logic [$clog2(DEPTH_A):0] a_count;
   logic [$clog2(DEPTH_B):0] b_count;

   stim_trace_unit #(.DATA_W(DW), .TS_W(TW), .DEPTH(DEPTH_A), .TIMEOUT(TO_A)) u_a (
      .clk(clk), .rst(rst_a), .start(start), .stop(stop), .cfg_mode(cfg_mode),
      .cfg_const(cfg_const), .stim_out(a_stim), .dut_out(dut_in), .trace_valid(a_valid),
      .trace_data(a_data), .trace_ts(a_ts), .trace_rd(trace_rd), .trace_count(a_count),
      .overflow(a_ovf), .running(a_run), .done(a_done));

   stim_trace_unit #(.DATA_W(DW), .TS_W(TW), .DEPTH(DEPTH_B), .TIMEOUT(TO_B)) u_b (
      .clk(clk), .rst(rst_b), .start(start), .stop(stop), .cfg_mode(cfg_mode),
      .cfg_const(cfg_const), .stim_out(b_stim), .dut_out(dut_in), .trace_valid(b_valid),
      .trace_data(b_data), .trace_ts(b_ts), .trace_rd(trace_rd), .trace_count(b_count),
      .overflow(b_ovf), .running(b_run), .done(b_done));

   logic [DW-1:0] c_stim, c_data;
   logic [TW-1:0] c_ts;
   logic          c_valid, c_ovf, c_run, c_done;
   int            c_count;

   always_comb begin
      if (sel == 0) begin
         c_stim = a_stim; c_data = a_data; c_ts = a_ts; c_valid = a_valid;
         c_ovf = a_ovf; c_run = a_run; c_done = a_done; c_count = int'(a_count);
      end else begin
         c_stim = b_stim; c_data = b_data; c_ts = b_ts; c_valid = b_valid;
         c_ovf = b_ovf; c_run = b_run; c_done = b_done; c_count = int'(b_count);
      end
   end

   typedef struct packed {
      logic [TW-1:0] ts;
      logic [DW-1:0] data;
   } entry_t;

   entry_t        exp_q[$];
   int            m_depth = DEPTH_A;
   int            m_timeout = TO_A;
   bit            m_running = 0, m_done = 0, m_ovf = 0, m_first = 0, popped = 0;
   logic [TW-1:0] m_ts = '0;
   logic [DW-1:0] m_stim = '0, m_prev = '0;
   bit            chk_en = 0;
   int            n_checks = 0;
   int            n_fail = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] lfsr_at(logic [TW-1:0] n);
      logic [31:0] l = 32'h1;
      for (int i = 0; i < int'(n); i++)
         l = l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
      return l;
   endfunction

   function automatic logic [DW-1:0] exp_stim(logic [TW-1:0] t);
      case (cfg_mode)
         2'd0:    return t;
         2'd1:    return lfsr_at(t);
         2'd2:    return cfg_const;
         default: return m_stim;
      endcase
   endfunction

   // Reference model: advances on each rising edge from the inputs the bench applied.
   always @(posedge clk) begin
      if (rst) begin
         m_running = 0; m_done = 0; m_ovf = 0; m_first = 0;
         m_ts = '0; m_stim = '0; m_prev = '0;
         exp_q.delete();
      end else if (m_running) begin
         if (m_first || (dut_in != m_prev)) begin
            if (exp_q.size() < m_depth) exp_q.push_back(entry_t'({m_ts, dut_in}));
            else m_ovf = 1;
         end
         m_first = 0;
         m_prev  = dut_in;
         if (stop || (m_timeout != 0 && m_ts == TW'(m_timeout - 1))) begin
            m_running = 0;
            m_done    = 1;
         end else begin
            m_ts   = m_ts + 1;
            m_stim = exp_stim(m_ts);
         end
      end else if (start) begin
         m_running = 1; m_done = 0; m_ovf = 0; m_first = 1;
         exp_q.delete();
         m_ts   = '0;
         m_stim = exp_stim('0);
      end
      popped = 0;
   end

   // Scoreboard monitor: compares status and the FIFO head; pops on a read.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("running", c_run, m_running);
         chk("done", c_done, m_done);
         chk("overflow", c_ovf, m_ovf);
         chk("stim_out", c_stim, m_stim);
         chk("trace_count", c_count, exp_q.size());
         chk("trace_valid", c_valid, exp_q.size() != 0);
         if (exp_q.size() > 0) begin
            chk("head_ts", c_ts, exp_q[0].ts);
            chk("head_data", c_data, exp_q[0].data);
            if (trace_rd) begin
               void'(exp_q.pop_front());
               popped = 1;
            end
         end else begin
            chk("empty_ts", c_ts, 0);
            chk("empty_data", c_data, 0);
         end
      end
   end

   // dut_out source: 0 hold, 1 stim delayed one cycle, 2 stim direct, 3 random small, 4 increment
   int            src = 0;
   logic [DW-1:0] stim_hist = '0;
   initial forever begin
      @(posedge clk);
      #1;
      case (src)
         1: dut_in = stim_hist;
         2: dut_in = m_stim;
         3: dut_in = $urandom_range(0, 3);
         4: dut_in = dut_in + 1;
         default: ;
      endcase
      stim_hist = m_stim;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic use_inst(int s);
      rst = 1'b1;
      cyc();
      sel = s;
      m_depth   = (s == 0) ? DEPTH_A : DEPTH_B;
      m_timeout = (s == 0) ? TO_A : TO_B;
      cyc();
      rst = 1'b0;
   endtask

   task automatic random_phase(int ncyc);
      src = 3;
      for (int k = 0; k < ncyc; k++) begin
         start    = ($urandom_range(0, 7) == 0);
         stop     = ($urandom_range(0, 15) == 0);
         trace_rd = ($urandom_range(0, 2) == 0);
         cfg_mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) cfg_const = $urandom;
         if ($urandom_range(0, 19) == 0) src = $urandom_range(1, 4);
         cyc();
      end
      start = 1'b0; stop = 1'b0; trace_rd = 1'b0;
   endtask

   int n;

   initial begin
      cyc();
      chk_en = 1;
      cyc();
      rst = 1'b0;
      repeat (5) cyc();
      chk("idle_running", c_run, 0);
      chk("idle_done", c_done, 0);
      chk("idle_valid", c_valid, 0);
      chk("idle_stim", c_stim, 0);
      chk("idle_count", c_count, 0);
      chk("idle_data", c_data, 0);

      // Timeout run, mode 0, dut_out = stim_out delayed by one cycle
      cfg_mode = 2'd0;
      src = 1;
      pulse_start();
      n = 0;
      while (c_run && n < 50) begin
         n++;
         cyc();
      end
      chk("run_cycles_timeout", n, 8);
      chk("done_after_timeout", c_done, 1);
      chk("count_after_timeout", c_count, 7);
      trace_rd = 1'b1;
      for (int i = 0; i < 7; i++) begin
         chk("drain_ts", c_ts, (i == 0) ? 0 : i + 1);
         chk("drain_data", c_data, i);
         cyc();
      end
      trace_rd = 1'b0;
      chk("drained_valid", c_valid, 0);

      // LFSR sequence, dut_out = stim_out
      cfg_mode = 2'd1;
      src = 2;
      pulse_start();
      chk("lfsr0", c_stim, 32'h0000_0001);
      cyc();
      chk("lfsr1", c_stim, 32'h8020_0003);
      cyc();
      chk("lfsr2", c_stim, 32'hC030_0002);
      n = 0;
      while (c_run && n < 50) begin
         n++;
         cyc();
      end
      chk("lfsr_run_ends", c_run, 0);
      trace_rd = 1'b1;
      n = 0;
      while (c_valid && n < 50) begin
         n++;
         cyc();
      end
      trace_rd = 1'b0;

      random_phase(250);

      // Reset in the middle of a run
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      cfg_mode = 2'd0;
      src = 4;
      pulse_start();
      repeat (5) cyc();
      rst = 1'b1;
      cyc();
      chk("rst_running", c_run, 0);
      chk("rst_done", c_done, 0);
      chk("rst_count", c_count, 0);
      chk("rst_stim", c_stim, 0);
      rst = 1'b0;
      cyc();

      // Second instance: DEPTH=4, no timeout
      use_inst(1);
      cfg_mode = 2'd0;
      src = 4;
      pulse_start();
      repeat (10) cyc();
      chk("full_count", c_count, 4);
      chk("full_overflow", c_ovf, 1);
      trace_rd = 1'b1;
      cyc();
      trace_rd = 1'b0;
      chk("push_pop_full_count", c_count, 4);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      chk("stopped_done", c_done, 1);

      pulse_start();
      chk("restart_count", c_count, 0);
      chk("restart_overflow", c_ovf, 0);
      chk("restart_stim", c_stim, 0);
      n = 0;
      while (c_run && n < 50) begin
         n++;
         if (n == 4) stop = 1'b1;
         cyc();
         stop = 1'b0;
      end
      chk("run_cycles_stop", n, 4);
      chk("done_after_stop", c_done, 1);
      pulse_start();
      chk("restart2_count", c_count, 0);
      chk("restart2_overflow", c_ovf, 0);
      chk("restart2_running", c_run, 1);

      random_phase(300);
      repeat (3) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
